// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: holds HI/LO, runs fixed-latency mult/div
// sequences and raises a stall to the decode stage while HI/LO are in flight.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic [31:0]   a, b;

  logic [63:0] sa, sb, res;
  logic [31:0] mag_a, mag_b, uq, ur;
  logic        neg_q, neg_r;

  // Signed divide runs on magnitudes so -2^31 / -1 stays well defined.
  always_comb begin
    sa    = {{32{a[31]}}, a};
    sb    = {{32{b[31]}}, b};
    neg_q = (op_q == 2'd2) & (a[31] ^ b[31]);
    neg_r = (op_q == 2'd2) & a[31];
    mag_a = ((op_q == 2'd2) && a[31]) ? -a : a;
    mag_b = ((op_q == 2'd2) && b[31]) ? -b : b;
    uq    = mag_a / mag_b;
    ur    = mag_a % mag_b;
    case (op_q)
      2'd0:    res = sa * sb;
      2'd1:    res = {32'd0, a} * {32'd0, b};
      default: res = {neg_r ? -ur : ur, neg_q ? -uq : uq};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      a     <= '0;
      b     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              state <= RUN;
              busy  <= 1'b1;
              a     <= rs_val;
              b     <= rt_val;
              op_q  <= op[1:0];
              cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (op == 3'd4) begin
              hi <= rs_val;
            end else if (op == 3'd5) begin
              lo <= rs_val;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // A zero divisor still burns the full latency but leaves HI/LO alone.
            if (!(op_q[1] && b == 32'd0)) {hi, lo} <= res;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = md_use & (busy | start);
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed and randomized checks of mdu_ctrl against a cycle-level model that
// tracks remaining latency and computes results with wide integer arithmetic.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, md_use;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .md_use(md_use), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int busy_cnt, done_cnt, stall_cnt;

  // reference model
  int          m_rem = 0;
  logic        m_done = 1'b0, p_wr = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic plan(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x) & 64'hFFFF_FFFF;
    uy = longint'(y) & 64'hFFFF_FFFF;
    p_wr = 1'b1;
    case (o)
      3'd0: begin q = sx * sy; p_hi = q[63:32]; p_lo = q[31:0]; end
      3'd1: begin p = ux * uy; p_hi = p[63:32]; p_lo = p[31:0]; end
      3'd2: if (y == 0) p_wr = 1'b0;
            else begin q = sx / sy; r = sx % sy; p_hi = r[31:0]; p_lo = q[31:0]; end
      default: if (y == 0) p_wr = 1'b0;
            else begin p = ux / uy; p_hi = p[31:0]; p = ux % uy; p_lo = p_hi; p_hi = p[31:0]; end
    endcase
    m_rem = (o[1]) ? 10 : 5;
  endtask

  task automatic model_edge(input logic r, input logic s, input logic [2:0] o,
                            input logic [31:0] x, input logic [31:0] y);
    m_done = 1'b0;
    if (r) begin
      m_rem = 0; m_hi = '0; m_lo = '0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_done = 1'b1;
        if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end else if (s) begin
      if (o <= 3'd3) plan(o, x, y);
      else if (o == 3'd4) m_hi = x;
      else if (o == 3'd5) m_lo = x;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] o,
                      input logic [31:0] x, input logic [31:0] y, input logic mu);
    @(negedge clk);
    reset = r; start = s; op = o; rs_val = x; rt_val = y; md_use = mu;
    #1;
    chk("stall", stall, mu & ((m_rem > 0) | s));
    stall_cnt += int'(stall);
    @(posedge clk);
    model_edge(r, s, o, x, y);
    #1;
    chk("busy", busy, m_rem > 0);
    chk("done", done, m_done);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    busy_cnt += int'(busy);
    done_cnt += int'(done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
  endtask

  task automatic clr;
    busy_cnt = 0; done_cnt = 0; stall_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0; md_use = 1'b0;
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    chk("rst_state", {busy, done, hi, lo}, '0);

    clr; step(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0); idle(6);
    chk("mult_busy_cycles", busy_cnt, 5);
    chk("mult_done_pulses", done_cnt, 1);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);

    clr; step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0); idle(6);
    chk("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

    clr; step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0); idle(11);
    chk("div_busy_cycles", busy_cnt, 10);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    step(1'b0, 1'b1, 3'd4, 32'h1234_5678, '0, 1'b0);
    step(1'b0, 1'b1, 3'd5, 32'h9ABC_DEF0, '0, 1'b0);
    clr; step(1'b0, 1'b1, 3'd3, 32'd77, 32'd0, 1'b0); idle(11);
    chk("divz_busy_cycles", busy_cnt, 10);
    chk("divz_done_pulses", done_cnt, 1);
    chk("divz_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

    clr; step(1'b0, 1'b1, 3'd0, 32'd3, 32'd7, 1'b1);
    step(1'b0, 1'b0, 3'd0, '0, '0, 1'b1);
    step(1'b0, 1'b1, 3'd5, 32'h0000_AAAA, '0, 1'b1);
    step(1'b0, 1'b0, 3'd0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 3'd0, '0, '0, 1'b1);
    chk("run_stall_cycles", stall_cnt, 5);
    idle(2);
    chk("mtlo_in_run_ignored", {hi, lo}, 64'd21);

    // start arriving on the completing edge is dropped
    step(1'b0, 1'b1, 3'd0, 32'd4, 32'd4, 1'b0); idle(4);
    step(1'b0, 1'b1, 3'd4, 32'hDEAD_BEEF, '0, 1'b0); idle(1);
    chk("start_at_done_ignored", {hi, lo}, 64'd16);

    clr; step(1'b0, 1'b1, 3'd2, 32'd100, 32'd7, 1'b0); idle(3);
    step(1'b1, 1'b0, 3'd0, '0, '0, 1'b0);
    chk("abort_state", {busy, hi, lo}, '0);
    idle(12);
    chk("abort_no_done", done_cnt, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, o, x, y,
           $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
